control_sequencer: RTL

- Moore FSM that drives the datapath control strobes for the register select/encode stage and the rest of the datapath.
- Runs the fetch / decode / execute step sequence for each instruction class, decided from the 5-bit opcode in IR[31:27].
- Its Gra/Grb/Grc/Rin/Rout/BAout outputs feed the register select/encode stage directly. The opcode that stage extracts from IR comes back in as this block's opcode input.

---
 rtl/control_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: Moore control FSM for the fetch/decode/execute datapath.
// Generates register select/encode strobes, datapath strobes, memory strobes
// and the ALU op select from the current step and the IR opcode class.
module control_sequencer #(
  parameter logic [4:0] ADD_OP      = 5'b00011,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       mem_done,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Cout,
  output logic       CONin,
  output logic       Read,
  output logic       Write,
  output logic [4:0] alu_op,
  output logic       run,
  output logic       fault
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_t;

  // Last counter value before a wait is declared timed out.
  localparam logic [3:0] CNT_LAST = 4'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;

  logic is_ld, is_ldi, is_st, is_alu3, is_alui, is_br, is_halt;
  logic in_wait, timeout;

  // Opcode class decode and memory-wait bookkeeping.
  always_comb begin
    is_ld   = (opcode == 5'b00000);
    is_ldi  = (opcode == 5'b00001);
    is_st   = (opcode == 5'b00010);
    is_alu3 = (opcode >= 5'b00011) && (opcode <= 5'b01011);
    is_alui = (opcode >= 5'b01100) && (opcode <= 5'b01110);
    is_br   = (opcode == 5'b10010);
    is_halt = (opcode == 5'b11011);
    in_wait = (state_q == S_T1) ||
              ((state_q == S_T6) && is_ld) ||
              ((state_q == S_T7) && is_st);
    timeout = in_wait && !mem_done && (cnt_q == CNT_LAST);
    cnt_d   = (in_wait && !mem_done && !timeout) ? cnt_q + 4'd1 : 4'd0;
    fault_d = fault_q | timeout;
  end

  // State, wait counter and sticky fault flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state selection per step and opcode class.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (timeout)       state_d = S_HALTED;
        else if (mem_done) state_d = S_T2;
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_halt) state_d = S_HALTED;
        else if (is_alu3 || is_alui || is_ldi || is_ld || is_st || is_br) state_d = S_T4;
        else state_d = S_T0;
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = (is_ld || is_st || is_br) ? S_T6 : S_T0;
      S_T6: begin
        if (is_ld) begin
          if (timeout)       state_d = S_HALTED;
          else if (mem_done) state_d = S_T7;
        end else if (is_st) begin
          state_d = S_T7;
        end else begin
          state_d = S_T0;
        end
      end
      S_T7: begin
        if (is_st) begin
          if (timeout)       state_d = S_HALTED;
          else if (mem_done) state_d = S_T0;
        end else begin
          state_d = S_T0;
        end
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode of the current step; every strobe defaults low.
  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = 6'b0;
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin} = 7'b0;
    {Yin, Zin, Zlowout, Cout, CONin, Read, Write} = 7'b0;
    alu_op = 5'b0;
    run    = (state_q != S_HALTED);
    fault  = fault_q;
    case (state_q)
      S_T0: {PCout, MARin, IncPC, Zin} = 4'b1111;
      S_T1: {Zlowout, PCin, Read, MDRin} = 4'b1111;
      S_T2: {MDRout, IRin} = 2'b11;
      S_T3: begin
        if (is_alu3 || is_alui)            {Grb, Rout, Yin} = 3'b111;
        else if (is_ld || is_ldi || is_st) {Grb, BAout, Yin} = 3'b111;
        else if (is_br)                    {Gra, Rout, CONin} = 3'b111;
      end
      S_T4: begin
        if (is_alu3) begin
          {Grc, Rout, Zin} = 3'b111;
          alu_op = opcode;
        end else if (is_alui) begin
          {Cout, Zin} = 2'b11;
          alu_op = opcode;
        end else if (is_ld || is_ldi || is_st) begin
          {Cout, Zin} = 2'b11;
          alu_op = ADD_OP;
        end else if (is_br) begin
          {PCout, Yin} = 2'b11;
        end
      end
      S_T5: begin
        if (is_alu3 || is_alui || is_ldi) {Zlowout, Gra, Rin} = 3'b111;
        else if (is_ld || is_st)          {Zlowout, MARin} = 2'b11;
        else if (is_br) begin
          {Cout, Zin} = 2'b11;
          alu_op = ADD_OP;
        end
      end
      S_T6: begin
        if (is_ld)                {Read, MDRin} = 2'b11;
        else if (is_st)           {Gra, Rout, MDRin} = 3'b111;
        else if (is_br && con_ff) {Zlowout, PCin} = 2'b11;
      end
      S_T7: begin
        if (is_ld)      {MDRout, Gra, Rin} = 3'b111;
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
